// File: rtl/mc6809e_bus_ctrl_if.sv
// Bus bundle between the 6809E core, the bus controller and the external address/data bus.
// master: the controller side; slave: the core/memory side driving requests and read data.
interface mc6809e_bus_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              E;
  logic              Q;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [DATA_W-1:0] CPU_DOUT;
  logic              CPU_RnW;
  logic              CPU_BA;
  logic [DATA_W-1:0] CPU_DIN;
  logic [ADDR_W-1:0] A_OUT;
  logic              A_OE;
  logic              RnW;
  logic [DATA_W-1:0] D_OUT;
  logic              D_OE;
  logic [DATA_W-1:0] D_IN;
  logic              MRDY;
  logic              CYC_END;
  logic              WAIT_TO;

  modport master (
    output E, Q, CPU_DIN, A_OUT, A_OE, RnW, D_OUT, D_OE, CYC_END, WAIT_TO,
    input  CPU_ADDR, CPU_DOUT, CPU_RnW, CPU_BA, D_IN, MRDY
  );

  modport slave (
    input  E, Q, CPU_DIN, A_OUT, A_OE, RnW, D_OUT, D_OE, CYC_END, WAIT_TO,
    output CPU_ADDR, CPU_DOUT, CPU_RnW, CPU_BA, D_IN, MRDY
  );
endinterface

// File: rtl/mc6809e_bus_ctrl.sv
// 6809E E/Q quadrature clock generator with a registered, cycle-accurate bus interface.
// Define MC6809E_BUS_WAIT_EN to build MRDY-driven E-high stretching and the WAIT_TO pulse.
module mc6809e_bus_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned QDIV     = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  mc6809e_bus_ctrl_if.master   bus
);

  localparam int unsigned    CntW    = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(QDIV - 1);

  typedef enum logic [1:0] {StP0, StP1, StP2, StP3} phase_e;

  phase_e            r_state;
  phase_e            w_state_d;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_d;
  logic              w_cnt_last;
  logic              w_enter_p1;
  logic              w_enter_p2;
  logic              w_exit;
  logic              w_e;
  logic              w_q;

  logic [ADDR_W-1:0] r_a_out;
  logic              r_rnw;
  logic              r_a_oe;
  logic [DATA_W-1:0] r_d_out;
  logic              r_d_oe;
  logic [DATA_W-1:0] r_cpu_din;
  logic              r_cyc_end;

  assign w_cnt_last = (r_cnt == CntLast);
  assign w_enter_p1 = (r_state == StP0) && w_cnt_last;
  assign w_enter_p2 = (r_state == StP1) && w_cnt_last;

`ifdef MC6809E_BUS_WAIT_EN
  localparam int unsigned     WaitW   = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  logic [WaitW-1:0] r_wait;
  logic [WaitW-1:0] w_wait_d;
  logic             w_timeout;
  logic             r_wait_to;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_wait <= '0;
    end else begin
      r_wait <= w_wait_d;
    end
  end
`endif

  // Phase state register
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= StP0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Next phase / counter; P3 may hold on its last count while memory is not ready
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_exit    = 1'b0;
`ifdef MC6809E_BUS_WAIT_EN
    w_wait_d  = r_wait;
    w_timeout = 1'b0;
`endif
    if (!w_cnt_last) begin
      w_cnt_d = r_cnt + 1'b1;
    end else begin
      w_cnt_d = '0;
      case (r_state)
        StP0: w_state_d = StP1;
        StP1: w_state_d = StP2;
        StP2: w_state_d = StP3;
        StP3: begin
`ifdef MC6809E_BUS_WAIT_EN
          if (!bus.MRDY && (r_wait != WaitMax)) begin
            w_cnt_d  = r_cnt;
            w_wait_d = r_wait + 1'b1;
          end else begin
            w_state_d = StP0;
            w_exit    = 1'b1;
            w_timeout = !bus.MRDY;
            w_wait_d  = '0;
          end
`else
          w_state_d = StP0;
          w_exit    = 1'b1;
`endif
        end
        default: w_state_d = StP0;
      endcase
    end
  end

  // E/Q decode
  always_comb begin
    w_e = 1'b0;
    w_q = 1'b0;
    case (r_state)
      StP1: w_q = 1'b1;
      StP2: begin
        w_e = 1'b1;
        w_q = 1'b1;
      end
      StP3: w_e = 1'b1;
      default: ;
    endcase
  end

  // Bus registers; a released bus (CPU_BA) overrides any enable set on the same edge
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_a_out   <= '0;
      r_rnw     <= 1'b1;
      r_a_oe    <= 1'b0;
      r_d_out   <= '0;
      r_d_oe    <= 1'b0;
      r_cpu_din <= '0;
      r_cyc_end <= 1'b0;
    end else begin
      r_cyc_end <= w_exit;
      if (w_enter_p1) begin
        r_a_out <= bus.CPU_ADDR;
        r_rnw   <= bus.CPU_RnW;
      end
      if (w_enter_p2) begin
        r_d_out <= bus.CPU_DOUT;
      end
      if (w_exit && r_rnw) begin
        r_cpu_din <= bus.D_IN;
      end
      if (bus.CPU_BA) begin
        r_a_oe <= 1'b0;
        r_d_oe <= 1'b0;
      end else begin
        if (w_enter_p1) begin
          r_a_oe <= 1'b1;
        end
        if (w_enter_p2) begin
          r_d_oe <= !bus.CPU_RnW;
        end else if (w_exit) begin
          r_d_oe <= 1'b0;
        end
      end
    end
  end

`ifdef MC6809E_BUS_WAIT_EN
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_wait_to <= 1'b0;
    end else begin
      r_wait_to <= w_timeout;
    end
  end

  assign bus.WAIT_TO = r_wait_to;
`else
  assign bus.WAIT_TO = 1'b0;
`endif

  assign bus.E       = w_e;
  assign bus.Q       = w_q;
  assign bus.A_OUT   = r_a_out;
  assign bus.RnW     = r_rnw;
  assign bus.A_OE    = r_a_oe;
  assign bus.D_OUT   = r_d_out;
  assign bus.D_OE    = r_d_oe;
  assign bus.CPU_DIN = r_cpu_din;
  assign bus.CYC_END = r_cyc_end;

endmodule

// File: tb/tb_mc6809e_bus_ctrl.sv
// Scoreboard bench for mc6809e_bus_ctrl (QDIV=4, MAX_WAIT=8); stretch expectations follow
// MC6809E_BUS_WAIT_EN. Each bus cycle is measured between CYC_END pulses and checked.
module tb_mc6809e_bus_ctrl;

  localparam int unsigned QDIV     = 4;
  localparam int unsigned MAX_WAIT = 8;
`ifdef MC6809E_BUS_WAIT_EN
  localparam bit W = 1'b1;
`else
  localparam bit W = 1'b0;
`endif

  logic CLK    = 1'b0;
  logic nRESET = 1'b0;

  mc6809e_bus_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mc6809e_bus_ctrl #(
    .ADDR_W  (16),
    .DATA_W  (8),
    .QDIV    (QDIV),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .CLK   (CLK),
    .nRESET(nRESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        ba;
    int          ba_at;
    int          stall;
    int          len;
    int          a_oe_n;
    int          d_oe_n;
    logic [7:0]  cpu_din;
    int          wt;
  } vec_t;

  typedef struct {
    int          idx;
    int          len;
    logic [15:0] a_out;
    logic        rnw;
    int          a_oe_n;
    int          d_oe_n;
    logic [7:0]  d_out;
    logic [7:0]  cpu_din;
    int          wt;
  } exp_t;

  exp_t sb_q[$];
  int   cur_stall = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc();
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (bus.CYC_END) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL cyc_end_timeout: got none expected CYC_END within 100 CLK");
    end
  endtask

  // Memory model: MRDY low for cur_stall ready-sample CLKs starting at the last nominal P3 CLK
  initial begin
    int p3n;
    p3n = 0;
    bus.MRDY = 1'b1;
    forever begin
      @(negedge CLK);
      if (bus.E && !bus.Q) p3n++;
      else p3n = 0;
      bus.MRDY = !(p3n >= int'(QDIV) && p3n < int'(QDIV) + cur_stall);
    end
  end

  // Monitor: a window runs from one CYC_END sample up to (excluding) the next
  initial begin
    bit          in_win;
    bit          q_seen;
    int          len, aoe, doe, wt;
    logic [15:0] a_cap;
    logic        rnw_cap;
    exp_t        e;
    in_win = 1'b0;
    q_seen = 1'b0;
    len = 0; aoe = 0; doe = 0; wt = 0;
    a_cap = '0;
    rnw_cap = 1'b0;
    forever begin
      @(negedge CLK);
      if (!nRESET) begin
        in_win = 1'b0;
      end else if (bus.CYC_END) begin
        if (in_win && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          wt += int'(bus.WAIT_TO);
          chk($sformatf("v%0d cycle_len", e.idx), len, e.len);
          chk($sformatf("v%0d a_out", e.idx), a_cap, e.a_out);
          chk($sformatf("v%0d rnw", e.idx), rnw_cap, e.rnw);
          chk($sformatf("v%0d a_oe_clks", e.idx), aoe, e.a_oe_n);
          chk($sformatf("v%0d d_oe_clks", e.idx), doe, e.d_oe_n);
          chk($sformatf("v%0d d_out", e.idx), bus.D_OUT, e.d_out);
          chk($sformatf("v%0d cpu_din", e.idx), bus.CPU_DIN, e.cpu_din);
          chk($sformatf("v%0d wait_to", e.idx), wt, e.wt);
        end
        in_win = 1'b1;
        len    = 1;
        aoe    = int'(bus.A_OE);
        doe    = int'(bus.D_OE);
        wt     = 0;
        q_seen = 1'b0;
      end else if (in_win) begin
        len++;
        aoe += int'(bus.A_OE);
        doe += int'(bus.D_OE);
        wt  += int'(bus.WAIT_TO);
        if (bus.Q && !q_seen) begin
          q_seen  = 1'b1;
          a_cap   = bus.A_OUT;
          rnw_cap = bus.RnW;
        end
      end
    end
  end

  // Stimulus
  initial begin
    vec_t v[7];
    int   k;
    //        addr      rnw   dout   din    ba    at stall len           a_oe         d_oe        din    wt
    v[0] = '{16'hA5F0, 1'b1, 8'h00, 8'h3C, 1'b0, 0, 0,   16,           16,          0,          8'h3C, 0};
    v[1] = '{16'h1234, 1'b0, 8'h81, 8'h55, 1'b0, 0, 0,   16,           16,          8,          8'h3C, 0};
    v[2] = '{16'h0F0F, 1'b1, 8'h00, 8'hA7, 1'b0, 0, 3,   W ? 19 : 16,  W ? 19 : 16, 0,          8'hA7, 0};
    v[3] = '{16'h8001, 1'b0, 8'h5A, 8'h00, 1'b0, 0, 255, W ? 24 : 16,  W ? 24 : 16, W ? 16 : 8, 8'hA7,
             W ? 1 : 0};
    v[4] = '{16'h4444, 1'b0, 8'hC3, 8'h00, 1'b0, 9, 0,   16,           10,          2,          8'hA7, 0};
    v[5] = '{16'hFFFF, 1'b1, 8'h00, 8'h99, 1'b0, 0, 0,   16,           12,          0,          8'h99, 0};
    v[6] = '{16'h2222, 1'b1, 8'h00, 8'h11, 1'b1, 0, 0,   16,           1,           0,          8'h11, 0};

    bus.CPU_ADDR = '0;
    bus.CPU_DOUT = '0;
    bus.CPU_RnW  = 1'b1;
    bus.CPU_BA   = 1'b0;
    bus.D_IN     = '0;

    repeat (2) @(negedge CLK);
    chk("reset E", bus.E, 0);
    chk("reset Q", bus.Q, 0);
    chk("reset A_OE", bus.A_OE, 0);
    chk("reset D_OE", bus.D_OE, 0);
    chk("reset RnW", bus.RnW, 1);
    chk("reset A_OUT", bus.A_OUT, 0);
    chk("reset D_OUT", bus.D_OUT, 0);
    chk("reset CPU_DIN", bus.CPU_DIN, 0);
    chk("reset CYC_END", bus.CYC_END, 0);
    chk("reset WAIT_TO", bus.WAIT_TO, 0);
    nRESET = 1'b1;

    wait_cyc();
    foreach (v[i]) begin
      bus.CPU_ADDR = v[i].addr;
      bus.CPU_RnW  = v[i].rnw;
      bus.CPU_DOUT = v[i].dout;
      bus.D_IN     = v[i].din;
      bus.CPU_BA   = v[i].ba;
      cur_stall    = v[i].stall;
      sb_q.push_back('{i, v[i].len, v[i].addr, v[i].rnw, v[i].a_oe_n, v[i].d_oe_n, v[i].dout,
                       v[i].cpu_din, v[i].wt});
      if (v[i].ba_at > 0) begin
        repeat (v[i].ba_at) @(negedge CLK);
        bus.CPU_BA = 1'b1;
      end
      wait_cyc();
    end

    // Reset asserted in the middle of E-high of a write
    bus.CPU_ADDR = 16'h7777;
    bus.CPU_RnW  = 1'b0;
    bus.CPU_DOUT = 8'h66;
    bus.CPU_BA   = 1'b0;
    cur_stall    = 0;
    for (k = 0; k < 64; k++) begin
      @(negedge CLK);
      if (bus.E && bus.Q) break;
    end
    chk("pre-reset D_OE in P2", bus.D_OE, 1);
    #2 nRESET = 1'b0;
    #1;
    chk("mid-reset E", bus.E, 0);
    chk("mid-reset Q", bus.Q, 0);
    chk("mid-reset D_OE", bus.D_OE, 0);
    chk("mid-reset A_OE", bus.A_OE, 0);
    chk("mid-reset CPU_DIN", bus.CPU_DIN, 0);
    @(negedge CLK);
    #3 nRESET = 1'b1;
    for (k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (bus.E) break;
    end
    chk("first E rise after reset (CLK)", k, 2 * QDIV);
    chk("scoreboard drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
